// File: rtl/mux_rr_feeder.sv
// mux_rr_feeder: round-robin feeder for a 2:1 mux stage. Each producer channel has a
// one-word holding register. The arbiter picks one buffered word and presents it
// downstream through o_sel and an o_valid/i_ready handshake.
// Latency: a captured word shows o_valid=1 in the cycle after capture. A channel that
// is granted every cycle sustains one word per cycle. Backpressure: while
// o_valid && !i_ready, the grant is locked, so o_valid, o_sel, o_a and o_b hold steady.
// A full channel that is not being drained deasserts its ready.
// Ports:
//   i_clk, i_rst             clock and asynchronous active-high reset
//   i_a_* / o_a_ready        channel A producer valid/ready/data
//   i_b_* / o_b_ready        channel B producer valid/ready/data
//   o_a, o_b, o_sel          buffered words and select, wired to mux_if.i_a/i_b/i_sel
//   o_valid / i_ready        downstream handshake for the selected word
// Optional: with MUX_RR_FEEDER_STATS_EN defined, the module adds the outputs
//   o_grant_cnt_a and o_grant_cnt_b. These are saturating per-channel transfer counters.
module mux_rr_feeder #(
  parameter int DATA_WITH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_WITH-1:0] i_a_data,
  input  logic                 i_a_valid,
  output logic                 o_a_ready,
  input  logic [DATA_WITH-1:0] i_b_data,
  input  logic                 i_b_valid,
  output logic                 o_b_ready,
  output logic [DATA_WITH-1:0] o_a,
  output logic [DATA_WITH-1:0] o_b,
  output logic                 o_sel,
  output logic                 o_valid,
  input  logic                 i_ready
`ifdef MUX_RR_FEEDER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] o_grant_cnt_a,
  output logic [CNT_WIDTH-1:0] o_grant_cnt_b
`endif
);

  // CNT_WIDTH only sizes the optional counters. A zero width is never meaningful.
  if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
  end

  logic [DATA_WITH-1:0] a_q, a_d, b_q, b_d;
  logic                 a_full_q, a_full_d, b_full_q, b_full_d;
  logic                 prio_q, prio_d;     // 0: A wins a tie, 1: B wins a tie
  logic                 lock_q, lock_d;
  logic                 sel_q, sel_d;       // select remembered for the locked case
  logic                 sel, sel_free, xfer, xfer_a, xfer_b, cap_a, cap_b;
  logic                 a_rdy, b_rdy;

  always_comb begin
    sel_free = (a_full_q & b_full_q) ? prio_q : (b_full_q & ~a_full_q);
    // Once a stall is seen, the select is frozen until the word transfers.
    sel      = lock_q ? sel_q : sel_free;
    o_valid  = a_full_q | b_full_q;
    xfer     = o_valid & i_ready;
    xfer_a   = xfer & ~sel;
    xfer_b   = xfer & sel;
    // A granted channel that drains this cycle can refill in the same cycle.
    a_rdy    = ~i_rst & (~a_full_q | xfer_a);
    b_rdy    = ~i_rst & (~b_full_q | xfer_b);
    cap_a    = i_a_valid & a_rdy;
    cap_b    = i_b_valid & b_rdy;
    a_full_d = cap_a | (a_full_q & ~xfer_a);
    b_full_d = cap_b | (b_full_q & ~xfer_b);
    a_d      = cap_a ? i_a_data : a_q;
    b_d      = cap_b ? i_b_data : b_q;
    prio_d   = xfer ? ~sel : prio_q;
    lock_d   = o_valid & ~i_ready;
    sel_d    = sel;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      prio_q   <= 1'b0;
      lock_q   <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      prio_q   <= prio_d;
      lock_q   <= lock_d;
      sel_q    <= sel_d;
    end
  end

  assign o_a       = a_q;
  assign o_b       = b_q;
  assign o_sel     = sel;
  assign o_a_ready = a_rdy;
  assign o_b_ready = b_rdy;

`ifdef MUX_RR_FEEDER_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (xfer_a && (cnt_a_q != {CNT_WIDTH{1'b1}})) cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
    if (xfer_b && (cnt_b_q != {CNT_WIDTH{1'b1}})) cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign o_grant_cnt_a = cnt_a_q;
  assign o_grant_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_mux_rr_feeder.sv
// tb_mux_rr_feeder: directed table of per-cycle vectors for mux_rr_feeder, plus a
// hand-written streaming sequence for the grant counters.
// Inputs are driven on the falling edge. Outputs are sampled 1ns later, before the next rising edge.
module tb_mux_rr_feeder;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] i_a_data = '0, i_b_data = '0;
  logic          i_a_valid = 1'b0, i_b_valid = 1'b0, i_ready = 1'b0;
  logic          o_a_ready, o_b_ready, o_sel, o_valid;
  logic [DW-1:0] o_a, o_b, o_y;
`ifdef MUX_RR_FEEDER_STATS_EN
  logic [CW-1:0] o_grant_cnt_a, o_grant_cnt_b;
`endif

  mux_rr_feeder #(.DATA_WITH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_a_data(i_a_data), .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
    .i_b_data(i_b_data), .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
    .o_a(o_a), .o_b(o_b), .o_sel(o_sel), .o_valid(o_valid), .i_ready(i_ready)
`ifdef MUX_RR_FEEDER_STATS_EN
    , .o_grant_cnt_a(o_grant_cnt_a), .o_grant_cnt_b(o_grant_cnt_b)
`endif
  );

  // Downstream 2:1 mux that the consumer samples.
  assign o_y = o_sel ? o_b : o_a;

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rst, av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       rdy;
    logic       ev, es;
    logic [7:0] ey, eoa, eob;
    logic       ear, ebr;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_passed = 0;

  task automatic add(input logic rst, av, input logic [7:0] ad, input logic bv,
                     input logic [7:0] bd, input logic rdy, input logic ev, es,
                     input logic [7:0] ey, eoa, eob, input logic ear, ebr);
    vec_t v;
    v.rst = rst; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.rdy = rdy;
    v.ev = ev; v.es = es; v.ey = ey; v.eoa = eoa; v.eob = eob; v.ear = ear; v.ebr = ebr;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
  endtask

  initial begin
    logic       p_av, p_bv, p_ar, p_br, p_rst;
    logic [7:0] p_ad, p_bd;
    p_av = 0; p_bv = 0; p_ar = 0; p_br = 0; p_rst = 1; p_ad = 0; p_bd = 0;

    //   rst av ad    bv bd    rdy | ev es ey     eoa    eob    ear ebr
    add(1, 0, 8'h00, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 8'h00, 0, 0); // in reset
    add(0, 1, 8'h01, 0, 8'h00, 1,   0, 0, 8'h00, 8'h00, 8'h00, 1, 1); // A streaming
    add(0, 1, 8'h02, 0, 8'h00, 1,   1, 0, 8'h01, 8'h01, 8'h00, 1, 1);
    add(0, 1, 8'h03, 0, 8'h00, 1,   1, 0, 8'h02, 8'h02, 8'h00, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 0, 8'h03, 8'h03, 8'h00, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 8'h03, 8'h03, 8'h00, 1, 1); // empty, o_a kept
    add(0, 1, 8'h99, 0, 8'h00, 0,   0, 0, 8'h03, 8'h03, 8'h00, 1, 1); // fill A
    add(1, 0, 8'h00, 0, 8'h00, 1,   0, 0, 8'h00, 8'h00, 8'h00, 0, 0); // reset with A full
    add(0, 1, 8'h3C, 0, 8'h00, 1,   0, 0, 8'h00, 8'h00, 8'h00, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0,   1, 0, 8'h3C, 8'h3C, 8'h00, 0, 1); // stall
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 0, 8'h3C, 8'h3C, 8'h00, 1, 1);
    add(1, 0, 8'h00, 0, 8'h00, 0,   0, 0, 8'h00, 8'h00, 8'h00, 0, 0); // reset -> prio A
    add(0, 1, 8'hAA, 1, 8'hBB, 0,   0, 0, 8'h00, 8'h00, 8'h00, 1, 1); // both capture
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 0, 8'hAA, 8'hAA, 8'hBB, 1, 0); // A first
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 1, 8'hBB, 8'hAA, 8'hBB, 1, 1); // then B
    add(0, 1, 8'hA1, 1, 8'hB1, 0,   0, 0, 8'hAA, 8'hAA, 8'hBB, 1, 1);
    add(0, 1, 8'hA2, 1, 8'hB2, 1,   1, 0, 8'hA1, 8'hA1, 8'hB1, 1, 0); // alternate
    add(0, 1, 8'hA3, 1, 8'hB2, 1,   1, 1, 8'hB1, 8'hA2, 8'hB1, 0, 1);
    add(0, 1, 8'hA3, 1, 8'hB3, 1,   1, 0, 8'hA2, 8'hA2, 8'hB2, 1, 0);
    add(0, 0, 8'h00, 1, 8'hB3, 1,   1, 1, 8'hB2, 8'hA3, 8'hB2, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 0, 8'hA3, 8'hA3, 8'hB3, 1, 0);
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 1, 8'hB3, 8'hA3, 8'hB3, 1, 1);
    add(0, 0, 8'h00, 1, 8'h55, 0,   0, 0, 8'hA3, 8'hA3, 8'hB3, 1, 1); // fill B only
    add(0, 0, 8'h00, 0, 8'h00, 0,   1, 1, 8'h55, 8'hA3, 8'h55, 1, 0); // stall 1
    add(0, 1, 8'h11, 0, 8'h00, 0,   1, 1, 8'h55, 8'hA3, 8'h55, 1, 0); // stall 2, A fills
    add(0, 0, 8'h00, 0, 8'h00, 0,   1, 1, 8'h55, 8'h11, 8'h55, 0, 0); // stall 3, lock holds
    add(0, 1, 8'h77, 0, 8'h00, 0,   1, 1, 8'h55, 8'h11, 8'h55, 0, 0); // A full, not granted
    add(0, 1, 8'h77, 0, 8'h00, 1,   1, 1, 8'h55, 8'h11, 8'h55, 0, 1); // 0x55 transfers
    add(0, 1, 8'h77, 0, 8'h00, 1,   1, 0, 8'h11, 8'h11, 8'h55, 1, 1); // 0x11, refill 0x77
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 0, 8'h77, 8'h77, 8'h55, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0,   0, 0, 8'h77, 8'h77, 8'h55, 1, 1);
    add(0, 0, 8'h00, 1, 8'hC1, 0,   0, 0, 8'h77, 8'h77, 8'h55, 1, 1);
    add(0, 1, 8'hD1, 0, 8'h00, 1,   1, 1, 8'hC1, 8'h77, 8'hC1, 1, 1); // B xfer, A capture
    add(0, 0, 8'h00, 0, 8'h00, 1,   1, 0, 8'hD1, 8'hD1, 8'hC1, 1, 1);
    add(0, 0, 8'h00, 0, 8'h00, 1,   0, 0, 8'hD1, 8'hD1, 8'hC1, 1, 1);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge i_clk);
      // Producer rules: a pending, unaccepted word must be held with stable data.
      if (!p_rst && !vq[i].rst && p_av && !p_ar)
        check("prod_a_hold", i, {23'd0, vq[i].av, vq[i].ad}, {23'd0, 1'b1, p_ad});
      if (!p_rst && !vq[i].rst && p_bv && !p_br)
        check("prod_b_hold", i, {23'd0, vq[i].bv, vq[i].bd}, {23'd0, 1'b1, p_bd});
      i_rst     = vq[i].rst;
      i_a_valid = vq[i].av;
      i_a_data  = vq[i].ad;
      i_b_valid = vq[i].bv;
      i_b_data  = vq[i].bd;
      i_ready   = vq[i].rdy;
      #1;
      check("o_valid",   i, 32'(o_valid),   32'(vq[i].ev));
      check("o_sel",     i, 32'(o_sel),     32'(vq[i].es));
      check("o_y",       i, 32'(o_y),       32'(vq[i].ey));
      check("o_a",       i, 32'(o_a),       32'(vq[i].eoa));
      check("o_b",       i, 32'(o_b),       32'(vq[i].eob));
      check("o_a_ready", i, 32'(o_a_ready), 32'(vq[i].ear));
      check("o_b_ready", i, 32'(o_b_ready), 32'(vq[i].ebr));
      p_rst = vq[i].rst; p_av = vq[i].av; p_ad = vq[i].ad; p_ar = o_a_ready;
      p_bv = vq[i].bv; p_bd = vq[i].bd; p_br = o_b_ready;
    end

    // A streams five words after a fresh reset. Each word transfers the cycle after
    // its capture, and the A grant count saturates at 3.
    @(negedge i_clk);
    i_rst = 1; i_a_valid = 0; i_b_valid = 0; i_ready = 0;
    @(negedge i_clk);
    i_rst = 0;
    for (int i = 0; i <= 6; i++) begin
      @(negedge i_clk);
      i_a_valid = (i < 5);
      i_a_data  = 8'(i + 1);
      i_ready   = 1'b1;
      #1;
      check("stream_a_ready", 100 + i, 32'(o_a_ready), 32'd1);
      if (i >= 1) begin
        check("stream_valid", 100 + i, 32'(o_valid), (i <= 5) ? 32'd1 : 32'd0);
        check("stream_sel",   100 + i, 32'(o_sel),   32'd0);
        if (i <= 5) check("stream_y", 100 + i, 32'(o_y), 32'(i));
`ifdef MUX_RR_FEEDER_STATS_EN
        check("grant_cnt_a", 100 + i, 32'(o_grant_cnt_a), (i - 1 > 3) ? 32'd3 : 32'(i - 1));
        check("grant_cnt_b", 100 + i, 32'(o_grant_cnt_b), 32'd0);
`endif
      end
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_feeder.md
Name: mux_rr_feeder

Overview:
- Upstream stage of mux2to1; drives one mux_if instance (i_a, i_b, i_sel) from two independent valid/ready producer channels.
- Buffers one word per channel and arbitrates round-robin between them.
- Presents the granted word to the downstream consumer via o_sel plus an o_valid/i_ready handshake.
- Consumer samples the mux output o_y in the same cycle the handshake completes.

Parameters:
- DATA_WITH, 8, width of both data channels and of the mux data path.
- CNT_WIDTH, 16, width of the grant counters (optional feature only).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_a_data  input  DATA_WITH  channel A producer data.
- i_a_valid  input  1  channel A data valid.
- o_a_ready  output  1  channel A can accept.
- i_b_data  input  DATA_WITH  channel B producer data.
- i_b_valid  input  1  channel B data valid.
- o_b_ready  output  1  channel B can accept.
- o_a  output  DATA_WITH  buffered A word; drives mux_if.i_a.
- o_b  output  DATA_WITH  buffered B word; drives mux_if.i_b.
- o_sel  output  1  0 selects A, 1 selects B; drives mux_if.i_sel.
- o_valid  output  1  selected word is valid.
- i_ready  input  1  consumer accepts the selected word.

Behaviour:
- Reset: i_clk and i_rst as named above; reset is asynchronous and active-high.
- Values forced while i_rst is high: o_a=0, o_b=0, o_sel=0, o_valid=0, a_full=0, b_full=0, prio=A, lock=0, o_a_ready=0, o_b_ready=0.
- After reset release: readies rise combinationally, with no extra cycle.
- Holding registers: a_full/o_a and b_full/o_b, one entry per channel.
- Capture: on i_x_valid && o_x_ready, o_x <= i_x_data and x_full <= 1. Capture adds no further latency, so o_valid is high the cycle after capture.
- When a register empties, o_x keeps its last value; it is not cleared.
- o_valid = a_full | b_full, combinational from state.
- Selection when not locked:
  - only A full -> sel=0.
  - only B full -> sel=1.
  - both full -> sel = prio (prio=A gives 0).
- Lock: if o_valid && !i_ready at a clock edge, lock <= 1 and the current sel is frozen.
- While locked, o_sel stays frozen even if the other channel fills; lock clears on transfer.
- Transfer: o_valid && i_ready clears the selected entry.
- prio after a transfer: A transfer -> prio=B; B transfer -> prio=A. This also applies when only one channel requested.
- Ready, per channel x: o_x_ready = !x_full || (o_valid && i_ready && sel==x).
- The same-cycle drain-and-refill path keeps full throughput of one word per cycle per channel when that channel is granted each cycle.
- Simultaneous capture on both channels is allowed.
- Capture into a channel that is not granted while the other channel transfers is independent.
- Reset mid-operation: buffered words are discarded, no transfer completes, and arbitration restarts with prio=A.
- Producer rules, required and checked by assertion in the bench: i_x_data stable while i_x_valid && !o_x_ready; i_x_valid does not drop before acceptance.
- Guarantee: o_valid never drops and o_sel/o_a/o_b never change while o_valid && !i_ready.

Optional Feature:
- Macro: MUX_RR_FEEDER_STATS_EN.
- Defined: adds outputs o_grant_cnt_a and o_grant_cnt_b [CNT_WIDTH-1:0].
  - Each increments on every transfer of its channel and saturates at all-ones.
  - Both reset to 0 on i_rst.
  - Both counters are registered; the count is visible the cycle after the transfer.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: i_rst=1 mid-stream with a_full=1 -> o_valid=0, o_a=0, o_sel=0, readies=0; after release, first A word 0x3C appears with o_valid=1 one cycle after capture.
- Single channel streaming: A sends 0x01,0x02,0x03 back-to-back with i_ready=1 -> o_sel=0 throughout; o_y sequence 0x01,0x02,0x03 on consecutive cycles; o_a_ready stays 1.
- Round-robin fairness: A and B both full (A=0xAA, B=0xBB) after reset, i_ready=1 -> first transfer 0xAA (sel=0), then 0xBB (sel=1); with both continuously refilled, grants alternate A,B,A,B.
- Lock under backpressure: only B full (0x55), i_ready=0 for 3 cycles, A fills on cycle 2 -> o_sel stays 1 and o_valid stays 1; on i_ready=1, 0x55 transfers, then A (0x11) transfers next cycle.
- Full-buffer stall: A full, not granted (B locked), i_a_valid=1 with 0x77 -> o_a_ready=0 and o_a unchanged until A drains.
- Stats (with MUX_RR_FEEDER_STATS_EN, CNT_WIDTH=2): 5 A transfers -> o_grant_cnt_a reads 1,2,3,3,3; o_grant_cnt_b=0.
